// File: rtl/led_effect_sequencer.sv
// Steps an 8-LED effect pattern (FILL/CHASE/BLINK/DRAIN) under a RUN/PAUSE FSM.
// Define LED_EFFECT_AUTO_EN to include automatic mode cycling (key_auto / auto_on).
module led_effect_sequencer #(
    parameter int DIV        = 12_500_000,
    parameter int AUTO_STEPS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_next,
    input  logic       key_pause,
    input  logic       key_auto,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       paused,
    output logic       auto_on,
    output logic       step
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    localparam logic [1:0] M_FILL  = 2'd0;
    localparam logic [1:0] M_CHASE = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic          run;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    led_q, led_d;
    logic [1:0]    mode_q, mode_d, mode_inc;
    logic          step_q, step_d;
    logic          tick, advance, auto_adv;

    function automatic logic [7:0] start_value(input logic [1:0] m);
        case (m)
            M_FILL:  return 8'h00;
            M_CHASE: return 8'h01;
            M_BLINK: return 8'hAA;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] next_pattern(input logic [1:0] m, input logic [7:0] cur);
        case (m)
            M_FILL:  return (cur == 8'hFF) ? 8'h00 : {cur[6:0], 1'b1};
            // Any corrupted (non-one-hot) value re-seeds the chase.
            M_CHASE: return ((cur != 8'h00) && ((cur & (cur - 8'd1)) == 8'h00))
                            ? {cur[6:0], cur[7]} : 8'h01;
            M_BLINK: return (cur == 8'hAA) ? 8'h55 : 8'hAA;
            default: return (cur == 8'h00) ? 8'hFF : {1'b0, cur[7:1]};
        endcase
    endfunction

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (key_pause) state_d = (state_q == RUN) ? PAUSE : RUN;
    end

    // FSM: outputs
    always_comb begin
        run    = (state_q == RUN);
        paused = (state_q == PAUSE);
    end

    assign tick     = run && (cnt_q == CNT_LAST);
    assign advance  = key_next || auto_adv;
    assign mode_inc = mode_q + 2'd1;

`ifdef LED_EFFECT_AUTO_EN
    localparam int AW = $clog2(AUTO_STEPS + 1);
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_STEPS - 1);

    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic          auto_on_q, auto_on_d;

    // The final tick of the run is consumed by the advance, not a pattern step.
    assign auto_adv = auto_on_q && tick && (auto_cnt_q == AUTO_LAST);

    always_comb begin
        auto_on_d  = auto_on_q ^ key_auto;
        auto_cnt_d = auto_cnt_q;
        if (advance)
            auto_cnt_d = '0;
        else if (tick && auto_on_q)
            auto_cnt_d = auto_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_on_q  <= 1'b0;
            auto_cnt_q <= '0;
        end else begin
            auto_on_q  <= auto_on_d;
            auto_cnt_q <= auto_cnt_d;
        end
    end

    assign auto_on = auto_on_q;
`else
    logic unused_key_auto;
    assign unused_key_auto = key_auto;
    assign auto_adv        = 1'b0;
    assign auto_on         = 1'b0;
`endif

    always_comb begin
        cnt_d  = cnt_q;
        led_d  = led_q;
        mode_d = mode_q;
        step_d = 1'b0;
        if (advance) begin
            mode_d = mode_inc;
            led_d  = start_value(mode_inc);
            cnt_d  = '0;
        end else if (tick) begin
            led_d  = next_pattern(mode_q, led_q);
            step_d = 1'b1;
            cnt_d  = '0;
        end else if (run) begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            led_q  <= 8'h00;
            mode_q <= M_FILL;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            mode_q <= mode_d;
            step_q <= step_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_effect_sequencer.sv
// Directed bench for led_effect_sequencer with DIV=4, AUTO_STEPS=3.
// Auto-cycling expectations follow LED_EFFECT_AUTO_EN as compiled.
module tb_led_effect_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_next, key_pause, key_auto;
    logic [7:0] led;
    logic [1:0] mode;
    logic       paused, auto_on, step;

    int checks = 0;
    int errors = 0;

    led_effect_sequencer #(.DIV(4), .AUTO_STEPS(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_next  (key_next),
        .key_pause (key_pause),
        .key_auto  (key_auto),
        .led       (led),
        .mode      (mode),
        .paused    (paused),
        .auto_on   (auto_on),
        .step      (step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_led, input logic [1:0] e_mode,
                           input logic e_paused, input logic e_step);
        chk({tag, "_led"},    led,            e_led);
        chk({tag, "_mode"},   {6'd0, mode},   {6'd0, e_mode});
        chk({tag, "_paused"}, {7'd0, paused}, {7'd0, e_paused});
        chk({tag, "_step"},   {7'd0, step},   {7'd0, e_step});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] fill_seq [9];
        logic [1:0] wrap_mode [4];
        logic [7:0] wrap_led [4];
        fill_seq  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00};
        wrap_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
        wrap_led  = '{8'h01, 8'hAA, 8'hFF, 8'h00};

        rst_n = 1'b0; key_next = 1'b0; key_pause = 1'b0; key_auto = 1'b0;
        cyc(2);
        chk_all("reset", 8'h00, 2'd0, 1'b0, 1'b0);
        chk("reset_auto_on", {7'd0, auto_on}, 8'h00);

        // FILL: a step every 4 cycles after release
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc(3);
            chk("fill_hold_step", {7'd0, step}, 8'h00);
            chk("fill_hold_led", led, (i == 0) ? 8'h00 : fill_seq[i-1]);
            cyc(1);
            chk_all("fill_step", fill_seq[i], 2'd0, 1'b0, 1'b1);
        end

        // Mode wrap through all four modes
        for (int i = 0; i < 4; i++) begin
            key_next = 1'b1;
            cyc(1);
            key_next = 1'b0;
            chk_all("wrap", wrap_led[i], wrap_mode[i], 1'b0, 1'b0);
            cyc(9);
        end

        // Pause in CHASE at 04
        key_next = 1'b1;
        cyc(1);
        key_next = 1'b0;
        chk_all("chase_start", 8'h01, 2'd1, 1'b0, 1'b0);
        cyc(4);
        chk_all("chase1", 8'h02, 2'd1, 1'b0, 1'b1);
        cyc(4);
        chk_all("chase2", 8'h04, 2'd1, 1'b0, 1'b1);
        cyc(2);
        key_pause = 1'b1;
        cyc(1);
        key_pause = 1'b0;
        chk_all("pause_enter", 8'h04, 2'd1, 1'b1, 1'b0);
        cyc(20);
        chk_all("pause_hold", 8'h04, 2'd1, 1'b1, 1'b0);
        key_pause = 1'b1;
        cyc(1);
        key_pause = 1'b0;
        chk_all("resume", 8'h04, 2'd1, 1'b0, 1'b0);
        cyc(1);
        chk_all("resume_tick", 8'h08, 2'd1, 1'b0, 1'b1);

        // BLINK, then key_next colliding with the tick
        key_next = 1'b1;
        cyc(1);
        key_next = 1'b0;
        chk_all("blink_start", 8'hAA, 2'd2, 1'b0, 1'b0);
        cyc(4);
        chk_all("blink1", 8'h55, 2'd2, 1'b0, 1'b1);
        cyc(3);
        key_next = 1'b1;
        cyc(1);
        key_next = 1'b0;
        chk_all("collision", 8'hFF, 2'd3, 1'b0, 1'b0);

        // DRAIN step, pause mid-count, then async reset between edges
        cyc(4);
        chk_all("drain1", 8'h7F, 2'd3, 1'b0, 1'b1);
        cyc(1);
        key_pause = 1'b1;
        cyc(1);
        key_pause = 1'b0;
        chk_all("drain_pause", 8'h7F, 2'd3, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_all("async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
        chk("async_rst_auto_on", {7'd0, auto_on}, 8'h00);
        cyc(1);
        rst_n = 1'b1;

        // Auto-cycling in FILL
        key_auto = 1'b1;
        cyc(1);
        key_auto = 1'b0;
`ifdef LED_EFFECT_AUTO_EN
        chk("auto_on", {7'd0, auto_on}, 8'h01);
        cyc(3);
        chk_all("auto1", 8'h01, 2'd0, 1'b0, 1'b1);
        cyc(4);
        chk_all("auto2", 8'h03, 2'd0, 1'b0, 1'b1);
        cyc(4);
        chk_all("auto_adv", 8'h01, 2'd1, 1'b0, 1'b0);
`else
        chk("auto_off", {7'd0, auto_on}, 8'h00);
        cyc(3);
        chk_all("noauto1", 8'h01, 2'd0, 1'b0, 1'b1);
        cyc(4);
        chk_all("noauto2", 8'h03, 2'd0, 1'b0, 1'b1);
        cyc(4);
        chk_all("noauto3", 8'h07, 2'd0, 1'b0, 1'b1);
`endif

        // key_pause and key_next together: both act
        key_pause = 1'b1;
        key_next  = 1'b1;
        cyc(1);
        key_pause = 1'b0;
        key_next  = 1'b0;
`ifdef LED_EFFECT_AUTO_EN
        chk_all("pause_next", 8'hAA, 2'd2, 1'b1, 1'b0);
        cyc(8);
        chk_all("pause_next_hold", 8'hAA, 2'd2, 1'b1, 1'b0);
`else
        chk_all("pause_next", 8'h01, 2'd1, 1'b1, 1'b0);
        cyc(8);
        chk_all("pause_next_hold", 8'h01, 2'd1, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_effect_sequencer.md
# led_effect_sequencer

Controller that sequences the front-panel 8-LED effect patterns on the TM1638 board. It divides the system clock into a step tick and owns a RUN/PAUSE state machine and the effect-mode register (FILL, CHASE, BLINK, DRAIN). Each step generates the next pattern for the active mode. It sits between the key-scan block, which supplies one-cycle key pulses, and the TM1638 display driver, which consumes `led[7:0]`.

## Interface
- `DIV`, 12_500_000: clk cycles per pattern step; legal range ≥ 2.
- `AUTO_STEPS`, 16: steps per mode before an automatic mode advance; legal range ≥ 1.
- `clk` in 1: system clock; every register is clocked on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `key_next` in 1: one-cycle pulse that advances the mode.
- `key_pause` in 1: one-cycle pulse that toggles RUN/PAUSE.
- `key_auto` in 1: one-cycle pulse that toggles auto-cycling.
- `led` out 8: current LED pattern (registered).
- `mode` out 2: active mode. 0=FILL, 1=CHASE, 2=BLINK, 3=DRAIN.
- `paused` out 1: high while the block is in PAUSE.
- `auto_on` out 1: high while auto-cycling is enabled.
- `step` out 1: one-cycle pulse, high in the first cycle a new stepped pattern is visible.

## Operation
- **Reset values:** `led`=8'h00, `mode`=0, `paused`=0, `auto_on`=0, `step`=0. The tick counter and the auto step counter also reset to 0.
- **Tick counter:** width $clog2(DIV). It counts 0..DIV-1, then wraps to 0. The internal tick is high when count==DIV-1 and the FSM is in RUN.
- **FSM states:**
  - RUN: the tick counter runs and patterns advance.
  - PAUSE: the tick counter, auto counter and `led` are frozen.
  - `key_pause` toggles the state. No other transition exists.
- **Next-pattern rules, applied on each tick:**
  - FILL: `{led[6:0],1'b1}`; 8'hFF goes to 8'h00. Nine-step cycle, start value 8'h00.
  - CHASE: rotate left; 8'h80 goes to 8'h01. Start value 8'h01. Any non-one-hot value goes to 8'h01.
  - BLINK: 8'hAA goes to 8'h55, and any other value goes to 8'hAA. Start value 8'hAA.
  - DRAIN: `{1'b0,led[7:1]}`; 8'h00 goes to 8'hFF. Start value 8'hFF.
- **Mode advance** (`key_next`, or an auto advance):
  - `mode` <= `mode`+1, wrapping 3 to 0.
  - `led` <= start value of the new mode.
  - Tick counter and auto counter are cleared to 0.
  - `step` stays 0.
  - This is allowed in PAUSE. The state remains PAUSE.
- **Auto-cycling:** while `auto_on` and RUN, every tick increments the auto counter. The tick that brings it to AUTO_STEPS performs a mode advance instead of a pattern step.
- **Simultaneous events:**
  - `key_next` and tick in the same cycle: one mode advance, no pattern step.
  - `key_next` and auto advance in the same cycle: `mode` increments once.
  - `key_pause` and tick in the same cycle: the tick is still taken, and the state toggles to PAUSE.
  - `key_pause` and `key_next` in the same cycle: both take effect.
- Key inputs held high for several cycles act once per high cycle. Debouncing is upstream's job.

## Timing
- The internal tick is combinational from the counter. `led`, `step` and `mode` update on the rising edge at which count==DIV-1.
- In RUN, `led` and `step` change on the DIVth edge after reset release or after a mode advance. `step` stays high for exactly one cycle.
- A key pulse sampled on edge N gives `mode`, `led`, `paused` and `auto_on` their new values immediately after edge N. Latency is one cycle.
- After resuming from PAUSE, the tick counter continues from its frozen value.
- When `rst_n` is asserted mid-step or mid-pause, all outputs go to their reset values immediately, with no clock edge needed. Operation restarts in RUN, FILL.

## Configuration
- **Macro `LED_EFFECT_AUTO_EN` defined:** auto-cycling is present as described above.
- **Macro not defined:**
  - The auto counter and auto logic are omitted.
  - `key_auto` is ignored.
  - `auto_on` is tied to 0.
  - Modes change only on `key_next`.

## Test plan
All scenarios use DIV=4 and AUTO_STEPS=3.
- **Reset and FILL:** release `rst_n` and hold the keys at 0. `led` must be 00, 01, 03, 07, … FF, 00, changing every 4 cycles, with `step` pulsing once per change.
- **Mode wrap:** pulse `key_next` 4 times, 10 cycles apart. `mode` must be 1, 2, 3, 0, and `led` must be 01, AA, FF, 00 one cycle after each pulse.
- **Pause:** pulse `key_pause` in CHASE at `led`=04. `paused`=1, and `led` stays 04 for 20 cycles. A second `key_pause` resumes; `led`=08 appears after the remaining tick count.
- **Collision:** assert `key_next` in the same cycle as the tick while in BLINK. `mode`=3, `led`=FF, `step`=0.
- **Auto (macro defined):** pulse `key_auto`, then run 3 ticks in FILL. `led` shows 01, 03, then `mode`=1 with `led`=01 on the 3rd tick. With the macro undefined, `auto_on` stays 0 and `mode` stays 0.
- **Async reset:** assert `rst_n`=0 mid-count while paused in DRAIN. All outputs go to their reset values before the next clk edge.
